// File: rtl/sram64x7_req_ctrl.sv
// sram64x7_req_ctrl: request-side controller for the 64x7 single-port SRAM macro.
// Accepts read/write requests over valid/ready, drives the macro pins
// combinationally from the accepted request, captures read data one cycle later
// and returns it through a small credit-managed response FIFO.
//
// Optional feature macro: SRAM64X7_REQ_CTRL_CLEAR_EN
//   defined   -> every reset is followed by a sweep that zeroes all 64 words
//   undefined -> INIT goes straight to RUN, array contents are left untouched
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | single cycle after reset, macro idle, no requests accepted
// ST_CLEAR | zeroing sweep, one word per cycle (clear macro builds only)
// ST_RUN   | normal request/response operation

module sram64x7_req_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 7,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [DATA_W-1:0] req_wmask_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              busy_o,
    output logic              mem_ce_in_o,
    output logic              mem_we_in_o,
    output logic [ADDR_W-1:0] mem_addr_in_o,
    output logic [DATA_W-1:0] mem_wd_in_o,
    output logic [DATA_W-1:0] mem_w_mask_in_o,
    input  logic [DATA_W-1:0] mem_rd_out_i
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e state_q, state_d;

`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [OCC_W-1:0]  occ;
    logic              fire;
    logic              pop;
    logic              push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshake and credit check: a read may only be accepted if its response
    // is guaranteed a FIFO slot, counting the in-flight read and this cycle's pop.
    always_comb begin
        pop         = rsp_valid_o && rsp_ready_i;
        push        = inflight_q;
        occ         = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        req_ready_o = (state_q == ST_RUN) && (occ < DEPTH_OCC);
        fire        = req_valid_i && req_ready_o;
        inflight_d  = fire && !req_we_i;
        busy_o      = (state_q != ST_RUN);
        rsp_valid_o = (count_q != '0);
        rsp_rdata_o = rsp_valid_o ? fifo_q[rd_ptr_q] : '0;
    end

    // Next-state logic and macro pin drive for each state.
    always_comb begin
        state_d         = state_q;
`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
        clr_cnt_d       = clr_cnt_q;
`endif
        mem_ce_in_o     = 1'b0;
        mem_we_in_o     = 1'b0;
        mem_addr_in_o   = '0;
        mem_wd_in_o     = '0;
        mem_w_mask_in_o = '0;
        case (state_q)
            ST_INIT: begin
`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
`else
                state_d   = ST_RUN;
`endif
            end
`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
            ST_CLEAR: begin
                mem_ce_in_o     = 1'b1;
                mem_we_in_o     = 1'b1;
                mem_addr_in_o   = clr_cnt_q;
                mem_w_mask_in_o = '1;
                clr_cnt_d       = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (fire) begin
                    mem_ce_in_o     = 1'b1;
                    mem_we_in_o     = req_we_i;
                    mem_addr_in_o   = req_addr_i;
                    mem_wd_in_o     = req_wdata_i;
                    mem_w_mask_in_o = req_wmask_i;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State, sweep counter, in-flight flag and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
            clr_cnt_q  <= '0;
`endif
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
            inflight_q <= inflight_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Response storage; contents are qualified by count_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rd_out_i;
        end
    end

endmodule

// File: tb/tb_sram64x7_req_ctrl.sv
// Self-checking bench for sram64x7_req_ctrl with a behavioural SRAM macro model.
// Honours SRAM64X7_REQ_CTRL_CLEAR_EN so it can be built with or without the sweep.

module tb_sram64x7_req_ctrl;

`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
    localparam int RUN_AT = 65;
`else
    localparam int RUN_AT = 1;
`endif
    localparam int DEPTH = 2;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [5:0] req_addr;
    logic [6:0] req_wdata;
    logic [6:0] req_wmask;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [6:0] rsp_rdata;
    logic       busy;
    logic       mem_ce;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [6:0] mem_wd;
    logic [6:0] mem_mask;
    logic [6:0] mem_rd;

    int tests_run    = 0;
    int tests_failed = 0;
    int tb_cyc       = 0;

    sram64x7_req_ctrl #(.ADDR_W(6), .DATA_W(7), .RSP_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_we_i        (req_we),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_wmask_i     (req_wmask),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_rdata_o     (rsp_rdata),
        .busy_o          (busy),
        .mem_ce_in_o     (mem_ce),
        .mem_we_in_o     (mem_we),
        .mem_addr_in_o   (mem_addr),
        .mem_wd_in_o     (mem_wd),
        .mem_w_mask_in_o (mem_mask),
        .mem_rd_out_i    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] init_val(input int a);
        return 7'(a) ^ 7'h2B;
    endfunction

    // Macro model: synchronous single-port RAM with per-bit write mask.
    logic [6:0] sram [64];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_mask) | (mem_wd & mem_mask);
            else        mem_rd <= sram[mem_addr];
        end
    end

    // Reference model: outstanding reads in order, each with the edge count
    // after which it becomes visible; cyc counts edges since reset release.
    typedef struct {
        logic [6:0] data;
        int         vis;
    } rsp_t;
    rsp_t       exp_q[$];
    logic [6:0] ref_mem [64];
    int         cyc = 0;
    logic [6:0] got_q[$];

    function automatic logic m_run();
        return cyc >= RUN_AT;
    endfunction
    function automatic logic m_head_vis();
        return (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    endfunction
    function automatic logic m_ready();
        int outstanding;
        outstanding = exp_q.size() - ((m_head_vis() && rsp_ready) ? 1 : 0);
        return m_run() && (outstanding < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            cyc = 0;
`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
            for (int i = 0; i < 64; i++) ref_mem[i] = 7'h00;
`endif
        end else begin
            logic rdy;
            rdy = m_ready();
            if (m_head_vis() && rsp_ready) void'(exp_q.pop_front());
            if (req_valid && rdy) begin
                if (req_we) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                else        exp_q.push_back('{data: ref_mem[req_addr], vis: cyc + 2});
            end
            cyc = cyc + 1;
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_busy", busy, 1);
            chk("rst_mem", {mem_ce, mem_we, mem_addr, mem_wd, mem_mask}, 0);
        end else begin
            logic       er, fire, hv;
            logic [6:0] e_rd;
            er   = m_ready();
            hv   = m_head_vis();
            fire = er && req_valid;
            e_rd = hv ? exp_q[0].data : 7'h00;
            chk("busy", busy, !m_run());
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, hv);
            chk("rsp_rdata", rsp_rdata, e_rd);
            if (m_run()) begin
                chk("mem_ce", mem_ce, fire);
                chk("mem_we", mem_we, fire && req_we);
                chk("mem_addr", mem_addr, fire ? req_addr : 6'h00);
                chk("mem_wd", mem_wd, fire ? req_wdata : 7'h00);
                chk("mem_mask", mem_mask, fire ? req_wmask : 7'h00);
            end else if (cyc >= 1) begin
                chk("clr_ce_we", {mem_ce, mem_we}, 2'b11);
                chk("clr_addr", mem_addr, cyc - 1);
                chk("clr_wd_mask", {mem_wd, mem_mask}, {7'h00, 7'h7F});
            end else begin
                chk("init_mem", {mem_ce, mem_we, mem_addr, mem_wd, mem_mask}, 0);
            end
        end
    end

    // Pops happen at the next edge because rsp_ready only changes after an edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) got_q.push_back(rsp_rdata);
    end

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
    endtask

    task automatic do_req(input logic we, input logic [5:0] a, input logic [6:0] d, input logic [6:0] m);
        logic ok;
        int   n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("req_accept_timeout", ok, 1);
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (got_q.size() < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rsp_wait", got_q.size() >= target, 1);
    endtask

    task automatic release_and_time();
        int n;
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_fall_cycles", n, RUN_AT);
    endtask

    initial begin
        int base, t0, idx, hold;
        logic acc;
        for (int i = 0; i < 64; i++) begin
            sram[i]    = init_val(i);
            ref_mem[i] = init_val(i);
        end
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        release_and_time();

`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
        base = got_q.size();
        for (int i = 0; i < 64; i++) do_req(1'b0, 6'(i), 7'h00, 7'h00);
        idle();
        wait_rsp(base + 64);
        for (int i = 0; i < 64; i++) chk("clear_word", got_q[base + i], 7'h00);
`endif

        // Data = address in the first ten words.
        for (int i = 0; i < 10; i++) do_req(1'b1, 6'(i), 7'(i), 7'h7F);

        // Back-to-back reads, one per cycle.
        base = got_q.size();
        t0   = tb_cyc;
        for (int i = 0; i < 10; i++) do_req(1'b0, 6'(i), 7'h00, 7'h00);
        chk("b2b_cycles", tb_cyc - t0, 10);
        idle();
        wait_rsp(base + 10);
        for (int i = 0; i < 10; i++) chk("b2b_data", got_q[base + i], i);

        // Masked write.
        base = got_q.size();
        do_req(1'b1, 6'd5, 7'h7F, 7'h7F);
        do_req(1'b1, 6'd5, 7'h00, 7'h0F);
        do_req(1'b0, 6'd5, 7'h00, 7'h00);
        idle();
        wait_rsp(base + 1);
        chk("masked_write", got_q[base], 7'h70);

        // Write-then-read hazard on the next cycle.
        base = got_q.size();
        do_req(1'b1, 6'd63, 7'h2A, 7'h7F);
        do_req(1'b0, 6'd63, 7'h00, 7'h00);
        idle();
        wait_rsp(base + 1);
        chk("hazard", got_q[base], 7'h2A);

        // Backpressure: only DEPTH reads fit while the consumer stalls.
        repeat (2) @(posedge clk);
        #1;
        base      = got_q.size();
        rsp_ready = 1'b0;
        idx       = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 6'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                req_addr = 6'(idx);
            end
        end
        chk("bp_accepted", idx, 2);
        chk("bp_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_same_cycle", req_ready, 1);
        do_req(1'b0, 6'd2, 7'h00, 7'h00);
        do_req(1'b0, 6'd3, 7'h00, 7'h00);
        idle();
        wait_rsp(base + 4);
        for (int i = 0; i < 4; i++) chk("bp_order", got_q[base + i], i);

        // Reset with responses queued and a read in flight.
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        do_req(1'b0, 6'd7, 7'h00, 7'h00);
        do_req(1'b0, 6'd8, 7'h00, 7'h00);
        rsp_ready = 1'b1;
        do_req(1'b0, 6'd9, 7'h00, 7'h00);
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 1);
        hold = got_q.size();
        repeat (3) @(posedge clk);
        #1;
        release_and_time();
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_rsp", got_q.size(), hold);

        base = got_q.size();
        do_req(1'b0, 6'd63, 7'h00, 7'h00);
        idle();
        wait_rsp(base + 1);
`ifdef SRAM64X7_REQ_CTRL_CLEAR_EN
        chk("post_reset_read", got_q[base], 7'h00);
`else
        chk("post_reset_read", got_q[base], 7'h2A);
`endif
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        tests_failed++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

endmodule
